// File: rtl/regfile_dbg_port_if.sv
// rtl/regfile_dbg_port_if.sv - request/response, halt and register-file port bundle for regfile_dbg_port
interface regfile_dbg_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        halt_req;
  logic        halted;
  logic        rf_sel;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic [31:0] rf_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, halted, rf_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, halt_req, rf_sel, rf_addr, rf_wd, rf_we
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, halted, rf_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, halt_req, rf_sel, rf_addr, rf_wd, rf_we
  );
endinterface

// File: rtl/regfile_dbg_port.sv
// rtl/regfile_dbg_port.sv - debug initiator: halts the core, performs one register-file access, responds
// Optional macro REGFILE_DBG_STICKY_HALT_EN keeps the halt asserted for HALT_HOLD idle cycles after a response.
module regfile_dbg_port #(
  parameter int HALT_TIMEOUT = 16,
  parameter int HALT_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_dbg_port_if.slave dbg
);
  typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

`ifdef REGFILE_DBG_STICKY_HALT_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_LAST = 8'(HALT_TIMEOUT - 1);
  localparam logic [7:0] HOLD_INIT    = STICKY_EN ? 8'(HALT_HOLD) : 8'd0;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic [7:0]  hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dbg.req_ready = 1'b0;
    dbg.rsp_valid = 1'b0;
    dbg.rsp_rdata = 32'd0;
    dbg.rsp_err   = 1'b0;
    dbg.halt_req  = 1'b1;
    dbg.rf_sel    = 1'b0;
    dbg.rf_addr   = 5'd0;
    dbg.rf_wd     = 32'd0;
    dbg.rf_we     = 1'b0;
    case (state)
      IDLE: begin
        dbg.req_ready = 1'b1;
        dbg.halt_req  = (hold_q != 8'd0);
        if (dbg.req_valid) state_nxt = HALT;
      end
      HALT: begin
        // halted wins over a timeout that would expire in the same cycle
        if (dbg.halted) state_nxt = ACCESS;
        else if (cnt_q == TIMEOUT_LAST) state_nxt = RESP;
      end
      ACCESS: begin
        dbg.rf_sel  = 1'b1;
        dbg.rf_addr = addr_q;
        dbg.rf_wd   = wdata_q;
        dbg.rf_we   = we_q & (addr_q != 5'd0);
        state_nxt   = RESP;
      end
      RESP: begin
        dbg.rsp_valid = 1'b1;
        dbg.rsp_rdata = rdata_q;
        dbg.rsp_err   = err_q;
        if (dbg.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg.req_valid) begin
            we_q    <= dbg.req_we;
            addr_q  <= dbg.req_addr;
            wdata_q <= dbg.req_wdata;
            cnt_q   <= 8'd0;
          end
        end
        HALT: begin
          if (!dbg.halted) begin
            if (cnt_q == TIMEOUT_LAST) begin
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (cnt_q != 8'hFF) begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ACCESS: begin
          err_q   <= 1'b0;
          rdata_q <= we_q ? 32'd0 : dbg.rf_rd;
        end
        default: ;
      endcase
    end
  end

  // Hold window after a response; a new request or an error response cancels it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else if (state == RESP && dbg.rsp_ready) begin
      hold_q <= err_q ? 8'd0 : HOLD_INIT;
    end else if (state == IDLE) begin
      if (dbg.req_valid) hold_q <= 8'd0;
      else if (hold_q != 8'd0) hold_q <= hold_q - 8'd1;
    end
  end
endmodule
